// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces the active-low push button,
// then derives a clean level, press/release/long-press strobes and a
// wrapping press counter for the control block.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 270_000,
  parameter int LONG_PRESS_CYCLES = 27_000_000,
  parameter int CNT_W             = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bbutton,
  output logic             pressed,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [2:0] IDLE             = 3'd0;
  localparam logic [2:0] DEBOUNCE_PRESS   = 3'd1;
  localparam logic [2:0] HELD             = 3'd2;
  localparam logic [2:0] LONG_HELD        = 3'd3;
  localparam logic [2:0] DEBOUNCE_RELEASE = 3'd4;

  logic              sync1;
  logic              sync2;
  logic [DB_W-1:0]   db_cnt;
  logic              pressed_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        state;
  logic [2:0]        state_next;

  logic db_done;
  logic hold_done;
  logic long_seen;

  // Debounce completes on the cycle the mismatch has lasted the full window.
  assign db_done   = (sync2 != pressed) && (db_cnt == DB_LAST);
  // Hold counter is about to reach the long-press threshold.
  assign hold_done = pressed && (hold_cnt == HOLD_LAST);
  // The current press has already produced (or is producing) its long strobe.
  assign long_seen = (hold_cnt == HOLD_MAX) || hold_done;

  // Two-flop synchroniser; inverts so that 1 means "button down".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~bbutton;
      sync2 <= sync1;
    end
  end

  // Stability counter: any return to agreement restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (sync2 == pressed) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      pressed <= sync2;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Edge strobes and press counter, one cycle behind the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_d     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      pressed_d     <= pressed;
      press_pulse   <= pressed & ~pressed_d;
      release_pulse <= ~pressed & pressed_d;
      if (pressed && !pressed_d) begin
        press_count <= press_count + CNT_W'(1);
      end
    end
  end

  // Saturating hold timer; the strobe fires only on the step into saturation,
  // so release bounces (pressed still 1) cannot retrigger it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else if (!pressed) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      long_pulse <= (hold_cnt == HOLD_LAST);
    end
  end

  // Next-state logic tracking the synchroniser/debounce/hold relationship.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sync2) state_next = DEBOUNCE_PRESS;
      end
      DEBOUNCE_PRESS: begin
        if (!sync2)       state_next = IDLE;
        else if (db_done) state_next = HELD;
      end
      HELD: begin
        if (!sync2)         state_next = DEBOUNCE_RELEASE;
        else if (hold_done) state_next = LONG_HELD;
      end
      LONG_HELD: begin
        if (!sync2) state_next = DEBOUNCE_RELEASE;
      end
      DEBOUNCE_RELEASE: begin
        if (sync2)        state_next = long_seen ? LONG_HELD : HELD;
        else if (db_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8,
// LONG_PRESS_CYCLES=64, CNT_W=4.
`timescale 1ns/1ps
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       bbutton;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [3:0] press_count;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (8),
    .LONG_PRESS_CYCLES(64),
    .CNT_W            (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bbutton      (bbutton),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #1.852 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_press, n_rel, n_long, n_both;
  int press_cyc, rel_cyc, long_cyc, rise_cyc;
  int any_pressed;
  logic prev_pressed = 1'b0;
  int t0, t1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_stats();
    n_press = 0; n_rel = 0; n_long = 0; n_both = 0;
    press_cyc = -1; rel_cyc = -1; long_cyc = -1; rise_cyc = -1;
    any_pressed = 0;
  endtask

  // Advance one clock, sample 1 ns after the edge, accumulate strobe events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse)   begin n_press++; press_cyc = cyc; end
    if (release_pulse) begin n_rel++;   rel_cyc   = cyc; end
    if (long_pulse)    begin n_long++;  long_cyc  = cyc; end
    if (press_pulse && release_pulse) n_both++;
    if (pressed === 1'b1) any_pressed = 1;
    if (pressed === 1'b1 && prev_pressed !== 1'b1) rise_cyc = cyc;
    prev_pressed = pressed;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_stats();
    bbutton = 1'b1;
    rst_n   = 1'b0;
    ticks(3);
    check("reset_pressed", pressed, 0);
    check("reset_count", press_count, 0);
    rst_n = 1'b1;

    // 1: idle button for 200 cycles
    clear_stats();
    ticks(200);
    check("idle_press_pulses", n_press, 0);
    check("idle_release_pulses", n_rel, 0);
    check("idle_long_pulses", n_long, 0);
    check("idle_pressed", any_pressed, 0);
    check("idle_count", press_count, 0);
    $display("step1 idle: presses=%0d count=%0d", n_press, press_count);

    // 2: single clean press, 25 cycles low
    clear_stats();
    t0 = cyc; bbutton = 1'b0;
    ticks(25);
    t1 = cyc; bbutton = 1'b1;
    ticks(20);
    check("short_press_pulses", n_press, 1);
    check("short_press_latency", press_cyc, t0 + 11);
    check("short_release_pulses", n_rel, 1);
    check("short_release_latency", rel_cyc, t1 + 11);
    check("short_long_pulses", n_long, 0);
    check("short_count", press_count, 1);
    $display("step2 press: press_at=+%0d release_at=+%0d count=%0d", press_cyc - t0, rel_cyc - t1, press_count);

    // 3: bounce with 3-cycle low/high pulses
    clear_stats();
    for (int r = 0; r < 10; r++) begin
      bbutton = 1'b0; ticks(3);
      bbutton = 1'b1; ticks(3);
    end
    ticks(20);
    check("bounce_pressed", any_pressed, 0);
    check("bounce_press_pulses", n_press, 0);
    check("bounce_release_pulses", n_rel, 0);
    check("bounce_count", press_count, 1);
    $display("step3 bounce: presses=%0d releases=%0d", n_press, n_rel);

    // 4: long press with a 4-cycle release glitch at cycle 90
    clear_stats();
    t0 = cyc; bbutton = 1'b0;
    ticks(90);
    bbutton = 1'b1; ticks(4);
    bbutton = 1'b0; ticks(6);
    check("long_rise_latency", rise_cyc, t0 + 10);
    check("long_pulse_latency", long_cyc, t0 + 74);
    check("long_pulse_count", n_long, 1);
    check("glitch_no_release", n_rel, 0);
    check("glitch_still_pressed", pressed, 1);
    check("long_count", press_count, 2);
    bbutton = 1'b1;
    ticks(20);
    check("long_final_release", n_rel, 1);
    check("long_no_retrigger", n_long, 1);
    check("long_released", pressed, 0);
    $display("step4 long: long_at=+%0d after rise, longs=%0d releases=%0d", long_cyc - rise_cyc, n_long, n_rel);

    // 5: reset the counter, then 17 clean presses to exercise the wrap
    rst_n = 1'b0; ticks(2); rst_n = 1'b1;
    clear_stats();
    for (int p = 1; p <= 17; p++) begin
      bbutton = 1'b0; ticks(15);
      bbutton = 1'b1; ticks(15);
      if (p == 15) check("wrap_count_15", press_count, 15);
      if (p == 16) check("wrap_count_16", press_count, 0);
    end
    check("wrap_press_pulses", n_press, 17);
    check("wrap_count_17", press_count, 1);
    $display("step5 wrap: presses=%0d count=%0d", n_press, press_count);

    // 6: reset asserted mid-press with the button still down
    bbutton = 1'b0;
    ticks(15);
    check("midreset_pressed_before", pressed, 1);
    clear_stats();
    rst_n = 1'b0;
    #0.2;
    check("midreset_async_pressed", pressed, 0);
    check("midreset_async_count", press_count, 0);
    ticks(3);
    t0 = cyc; rst_n = 1'b1;
    ticks(20);
    check("midreset_no_release", n_rel, 0);
    check("midreset_press_pulses", n_press, 1);
    check("midreset_press_latency", press_cyc, t0 + 11);
    check("midreset_count", press_count, 1);
    bbutton = 1'b1;
    ticks(20);
    check("never_both_pulses", n_both, 0);
    $display("step6 midreset: press_at=+%0d count=%0d releases=%0d", press_cyc - t0, press_count, n_rel);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw active-low push button (`bbutton`) before it reaches `control`. It synchronises the asynchronous pad input into the 27 MHz `clk` domain and debounces it with a stability counter. It then produces a clean level plus single-cycle press, release and long-press strobes, together with a wrapping press counter. `control` consumes `press_pulse`/`long_pulse` instead of sampling the pad directly.

## Interface
- `DEBOUNCE_CYCLES`, default 270_000 (10 ms at 27 MHz): consecutive stable cycles required before the debounced state changes; legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 27_000_000 (1 s): cycles `pressed` must stay high before `long_pulse` fires; must be > `DEBOUNCE_CYCLES`.
- `CNT_W`, default 8: width of `press_count`.
- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `bbutton` in 1: raw button pad, active low (0 = pressed), asynchronous to `clk`.
- `pressed` out 1: debounced level, 1 = button held.
- `press_pulse` out 1: one-cycle strobe on debounced press.
- `release_pulse` out 1: one-cycle strobe on debounced release.
- `long_pulse` out 1: one-cycle strobe when a press reaches `LONG_PRESS_CYCLES`.
- `press_count` out `CNT_W`: number of debounced presses, wraps modulo 2^`CNT_W`.

## Operation
- Synchroniser: two flops, `sync1 <= ~bbutton`, `sync2 <= sync1`. Both reset to 0, so a button held through reset is not a press until after reset releases plus the full debounce time.
- Debounce counter `db_cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - if `sync2 == pressed`, `db_cnt <= 0`.
  - else if `db_cnt == DEBOUNCE_CYCLES-1`, then `pressed <= sync2` and `db_cnt <= 0`.
  - else `db_cnt <= db_cnt + 1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` clears the count, so the output never changes.
- State machine, states IDLE, DEBOUNCE_PRESS, HELD, LONG_HELD, DEBOUNCE_RELEASE. The states mirror `pressed`, the `sync2`/`pressed` mismatch and the long flag:
  - IDLE→DEBOUNCE_PRESS when `sync2` = 1; back to IDLE if `sync2` returns to 0 before the count completes.
  - DEBOUNCE_PRESS→HELD when the count completes.
  - HELD→LONG_HELD when the hold count completes.
  - HELD or LONG_HELD→DEBOUNCE_RELEASE when `sync2` = 0; back to the origin state on a bounce.
  - DEBOUNCE_RELEASE→IDLE when the count completes.
- `press_pulse` is registered and high for exactly the one cycle after `pressed` rises. `release_pulse` is the same for `pressed` falling. They are never high in the same cycle.
- Hold counter `hold_cnt`:
  - cleared while `pressed` = 0.
  - increments while `pressed` = 1 and saturates at `LONG_PRESS_CYCLES`.
  - `long_pulse` is high for the one cycle in which `hold_cnt` transitions to `LONG_PRESS_CYCLES`. It fires at most once per press, and bounces during DEBOUNCE_RELEASE do not retrigger it.
- `press_count` increments in the same cycle `press_pulse` is asserted; it goes from 2^`CNT_W`-1 to 0 with no flag.

## Timing
- Reset (`rst_n` low, asynchronous) forces the following, with no pulses on reset deassertion:
  - `pressed`, `press_pulse`, `release_pulse`, `long_pulse` = 0.
  - `press_count` = 0.
  - all counters = 0.
  - state = IDLE.
- Press latency: with `bbutton` held low from the first sampling edge E, `pressed` = 1 after edge E+1+`DEBOUNCE_CYCLES` (2 synchroniser edges + `DEBOUNCE_CYCLES` count edges − 1 overlap). `press_pulse` follows one edge later.
- Release latency is identical, measured from the first edge sampling `bbutton` = 1.
- `long_pulse` occurs `LONG_PRESS_CYCLES` edges after `pressed` rises.
- Reset asserted mid-press: all outputs clear immediately and no `release_pulse` is emitted.
- A button still held after reset produces a fresh press after full latency; `press_count` restarts at 1.

## Test plan
Use `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=64, `CNT_W`=4 and a 3.704 ns clock for all scenarios.
1. Reset, then `bbutton` held at 1 for 200 cycles → all outputs stay 0; `press_count` = 0.
2. `bbutton` low for 25 cycles, then high → one `press_pulse` at latency 10 from the first low sample, one `release_pulse` at latency 10 from the first high sample, no `long_pulse`, `press_count` = 1.
3. Bounce: `bbutton` alternates 3-cycle low/high pulses for 60 cycles → `pressed` never rises; zero pulses.
4. `bbutton` low for 100 cycles → `long_pulse` exactly once, 64 cycles after `pressed` rises. A 4-cycle high glitch at cycle 90 produces no release and no second `long_pulse`.
5. 17 clean presses → `press_count` reads 1 after the 17th (wrap 15→0→1), with 17 `press_pulse` strobes.
6. `rst_n` pulsed low while `pressed` = 1 with `bbutton` still low → outputs clear asynchronously with no `release_pulse`; after release of `rst_n`, `press_pulse` appears 11 cycles later and `press_count` = 1.
